// File: rtl/recovery_pec_ctrl_if.sv
`default_nettype none
// =============================================================================
// recovery_pec_ctrl_if : RX byte stream, payload stream, PEC engine and status
// Revision: 1.0
// =============================================================================
interface recovery_pec_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] target_addr_i;
    logic              rx_start_i;
    logic              rx_stop_i;
    logic              rx_valid_i;
    logic [7:0]        rx_data_i;
    logic              rx_ready_o;
    logic              out_valid_o;
    logic [7:0]        out_data_o;
    logic              out_ready_i;
    logic [7:0]        cmd_o;
    logic [15:0]       len_o;
    logic              pec_valid_o;
    logic              pec_init_o;
    logic [7:0]        pec_dat_o;
    logic [7:0]        pec_crc_i;
    logic              done_o;
    logic              pec_ok_o;
    logic [2:0]        err_o;

    // Controller side
    modport slave (
        input  target_addr_i, rx_start_i, rx_stop_i, rx_valid_i, rx_data_i,
               out_ready_i, pec_crc_i,
        output rx_ready_o, out_valid_o, out_data_o, cmd_o, len_o,
               pec_valid_o, pec_init_o, pec_dat_o, done_o, pec_ok_o, err_o
    );

    // Environment side (RX target, downstream handler, PEC engine)
    modport master (
        output target_addr_i, rx_start_i, rx_stop_i, rx_valid_i, rx_data_i,
               out_ready_i, pec_crc_i,
        input  rx_ready_o, out_valid_o, out_data_o, cmd_o, len_o,
               pec_valid_o, pec_init_o, pec_dat_o, done_o, pec_ok_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/recovery_pec_ctrl.sv
`default_nettype none
// =============================================================================
// recovery_pec_ctrl : parses an I3C recovery write frame and sequences PEC check
// Revision: 1.0
// =============================================================================
module recovery_pec_ctrl #(
    parameter int MAX_LEN = 255,
    parameter int ADDR_W  = 7
) (
    input  wire                  clk_i,
    input  wire                  rst_ni,
    recovery_pec_ctrl_if.slave   bus
);
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        ADDR  = 4'd1,
        CMD   = 4'd2,
        LEN_L = 4'd3,
        LEN_H = 4'd4,
        DATA  = 4'd5,
        PEC   = 4'd6,
        TAIL  = 4'd7,
        DROP  = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic        len_err_q, len_err_d;
    logic        ovr_q, ovr_d;
    logic        match_q, match_d;

    logic        w_ready;
    logic        w_acc;
    logic [15:0] w_len;
    logic [7:0]  w_addr_byte;

    logic        w_out_valid, w_pec_valid, w_pec_init, w_done, w_pec_ok;
    logic [7:0]  w_out_data, w_pec_dat;
    logic [2:0]  w_err;

    assign w_ready = (state_q inside {CMD, LEN_L, LEN_H, PEC, TAIL, DROP}) ||
                     ((state_q == DATA) && bus.out_ready_i);
    assign w_acc       = bus.rx_valid_i && w_ready;
    assign w_len       = {bus.rx_data_i, len_q[7:0]};
    assign w_addr_byte = 8'({bus.target_addr_i[ADDR_W-1:0], 1'b0});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cmd_q     <= 8'h00;
            len_q     <= 16'h0000;
            cnt_q     <= 16'h0000;
            len_err_q <= 1'b0;
            ovr_q     <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
            ovr_q     <= ovr_d;
            match_q   <= match_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        len_err_d   = len_err_q;
        ovr_d       = ovr_q;
        match_d     = match_q;
        w_out_valid = 1'b0;
        w_out_data  = 8'h00;
        w_pec_valid = 1'b0;
        w_pec_init  = 1'b0;
        w_pec_dat   = 8'h00;
        w_done      = 1'b0;
        w_pec_ok    = 1'b0;
        w_err       = 3'b000;

        // Byte processing for the current state
        unique case (state_q)
            ADDR: begin
                w_pec_valid = 1'b1;
                w_pec_init  = 1'b1;
                w_pec_dat   = w_addr_byte;
                state_d     = CMD;
            end
            CMD: if (w_acc) begin
                cmd_d   = bus.rx_data_i;
                state_d = LEN_L;
            end
            LEN_L: if (w_acc) begin
                len_d[7:0] = bus.rx_data_i;
                state_d    = LEN_H;
            end
            LEN_H: if (w_acc) begin
                len_d[15:8] = bus.rx_data_i;
                cnt_d       = w_len;
                if (w_len > 16'(MAX_LEN)) begin
                    len_err_d = 1'b1;
                    state_d   = DROP;
                end else if (w_len == 16'h0000) begin
                    state_d = PEC;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: begin
                w_out_valid = bus.rx_valid_i;
                w_out_data  = bus.rx_data_i;
                if (w_acc) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = PEC;
                end
            end
            PEC: if (w_acc) begin
                match_d = (bus.rx_data_i == bus.pec_crc_i);
                state_d = TAIL;
            end
            TAIL: if (w_acc) ovr_d = 1'b1;
            default: ;
        endcase

        if (w_acc && (state_q inside {CMD, LEN_L, LEN_H, DATA})) begin
            w_pec_valid = 1'b1;
            w_pec_dat   = bus.rx_data_i;
        end

        // Status is judged on the post-byte view so a byte coinciding with STOP counts
        if (bus.rx_stop_i) begin
            if (!(state_q inside {IDLE, ADDR})) begin
                w_done = 1'b1;
                unique case (state_d)
                    TAIL: begin
                        w_pec_ok = match_d && !ovr_d;
                        w_err[2] = ovr_d;
                    end
                    DROP:    w_err[0] = 1'b1;
                    default: w_err[1] = 1'b1;
                endcase
            end
            state_d = IDLE;
        end

        if (bus.rx_start_i) begin
            w_done    = 1'b0;
            w_pec_ok  = 1'b0;
            w_err     = 3'b000;
            state_d   = ADDR;
            len_err_d = 1'b0;
            ovr_d     = 1'b0;
            match_d   = 1'b0;
        end
    end

    assign bus.rx_ready_o  = w_ready;
    assign bus.out_valid_o = w_out_valid;
    assign bus.out_data_o  = w_out_data;
    assign bus.cmd_o       = cmd_q;
    assign bus.len_o       = len_q;
    assign bus.pec_valid_o = w_pec_valid;
    assign bus.pec_init_o  = w_pec_init;
    assign bus.pec_dat_o   = w_pec_dat;
    assign bus.done_o      = w_done;
    assign bus.pec_ok_o    = w_pec_ok;
    assign bus.err_o       = w_err;

endmodule
`default_nettype wire

// File: tb/tb_recovery_pec_ctrl.sv
`default_nettype none
// =============================================================================
// tb_recovery_pec_ctrl : scoreboard bench with a CRC-8 engine model on the PEC port
// Revision: 1.0
// =============================================================================
module tb_recovery_pec_ctrl;
    logic clk;
    logic rst_n;

    recovery_pec_ctrl_if #(.ADDR_W(7)) bus ();

    recovery_pec_ctrl #(.MAX_LEN(255), .ADDR_W(7)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         strobes = 0;
    int         outs    = 0;
    logic [7:0] out_q[$];
    logic [3:0] st_q[$];
    logic [7:0] eng_crc;
    logic [7:0] exp_crc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    // Registered PEC engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               eng_crc <= 8'h00;
        else if (bus.pec_valid_o) eng_crc <= crc8(bus.pec_init_o ? 8'h00 : eng_crc, bus.pec_dat_o);
    end
    assign bus.pec_crc_i = eng_crc;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pec_valid_o) begin
                if (strobes == 0) check("first_init", 16'(bus.pec_init_o), 16'd1);
                strobes++;
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                outs++;
                if (out_q.size() == 0) check("out_unexpected", 16'd1, 16'd0);
                else check("out_data", 16'(bus.out_data_o), 16'(out_q.pop_front()));
            end
            if (bus.done_o) begin
                if (st_q.size() == 0) check("done_unexpected", 16'd1, 16'd0);
                else check("status", 16'({bus.pec_ok_o, bus.err_o}), 16'(st_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bit acc = 0;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.rx_ready_o) begin acc = 1; break; end
        end
        if (!acc) check("rx_accept_timeout", 16'd0, 16'd1);
        @(posedge clk); #1;
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic send_p(input logic [7:0] b);
        exp_crc = crc8(exp_crc, b);
        send(b);
    endtask

    task automatic send_d(input logic [7:0] b);
        out_q.push_back(b);
        send_p(b);
    endtask

    task automatic start();
        exp_crc = crc8(8'h00, {bus.target_addr_i, 1'b0});
        bus.rx_start_i = 1'b1;
        @(posedge clk); #1;
        bus.rx_start_i = 1'b0;
    endtask

    task automatic stop_exp(input logic [3:0] s);
        st_q.push_back(s);
        bus.rx_stop_i = 1'b1;
        @(posedge clk); #1;
        bus.rx_stop_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("done_seen", 16'(st_q.size()), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.target_addr_i = 7'h00;
        bus.rx_start_i    = 1'b0;
        bus.rx_stop_i     = 1'b0;
        bus.rx_valid_i    = 1'b0;
        bus.rx_data_i     = 8'h00;
        bus.out_ready_i   = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 16'(bus.rx_ready_o), 16'd0);
        check("rst_outs", 16'({bus.out_valid_o, bus.pec_valid_o, bus.done_o, bus.pec_ok_o, bus.err_o}), 16'd0);
        check("rst_cmd", 16'(bus.cmd_o), 16'h0000);
        check("rst_len", bus.len_o, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Good LEN=0 frame, address 0x00
        strobes = 0; outs = 0;
        start();
        send_p(8'h01);
        check("crc_after_cmd", 16'(eng_crc), 16'h0007);
        send_p(8'h00);
        send_p(8'h00);
        send(exp_crc);
        stop_exp(4'b1_000);
        check("strobe_count", 16'(strobes), 16'd4);
        check("no_out_len0", 16'(outs), 16'd0);
        check("cmd_latched", 16'(bus.cmd_o), 16'h0001);
        check("len_latched", bus.len_o, 16'h0000);

        // Corrupted PEC
        start();
        send_p(8'h01); send_p(8'h00); send_p(8'h00);
        send(exp_crc ^ 8'h01);
        stop_exp(4'b0_000);

        // LEN=4 with downstream stall
        bus.target_addr_i = 7'h5A;
        outs = 0;
        start();
        send_p(8'h20); send_p(8'h04); send_p(8'h00);
        send_d(8'hDE); send_d(8'hAD);
        fork
            begin
                bus.out_ready_i = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("ready_stalled", 16'(bus.rx_ready_o), 16'd0);
                end
                @(posedge clk); #1;
                bus.out_ready_i = 1'b1;
            end
        join_none
        send_d(8'hBE); send_d(8'hEF);
        send(exp_crc);
        stop_exp(4'b1_000);
        check("payload_count", 16'(outs), 16'd4);
        check("payload_drained", 16'(out_q.size()), 16'd0);
        check("len4_latched", bus.len_o, 16'h0004);

        // LEN over MAX_LEN
        outs = 0;
        start();
        send_p(8'h30); send_p(8'h00); send_p(8'h01);
        send(8'h11); send(8'h22);
        stop_exp(4'b0_001);
        check("no_out_drop", 16'(outs), 16'd0);

        // Short frame
        start();
        send_p(8'h10); send_p(8'h02); send_p(8'h00);
        send_d(8'h55);
        stop_exp(4'b0_010);

        // Overrun after PEC
        start();
        send_p(8'h01); send_p(8'h00); send_p(8'h00);
        send(exp_crc);
        send(8'h99);
        stop_exp(4'b0_100);

        // Restart mid-DATA, then a clean frame
        start();
        send_p(8'h40); send_p(8'h03); send_p(8'h00);
        send_d(8'h77);
        start();
        send_p(8'h41); send_p(8'h01); send_p(8'h00);
        send_d(8'h88);
        send(exp_crc);
        stop_exp(4'b1_000);
        check("restart_cmd", 16'(bus.cmd_o), 16'h0041);
        check("restart_len", bus.len_o, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
